byteblast8_exec_unit: RTL and testbench
=======================================

// Module: byteblast8_exec_unit
// PURPOSE
//  Decode/execute core of the ByteBlast 8-bit CPU.
//  - Half-rate clock divider provides the fetch/decode/execute phase clock.
//  - Instruction controller latches the RAM byte and splits it into opcode and operand address.
//  - 8-bit ALU computes the next accumulator value from the RAM operand and the current accumulator.
//  - Sits between the RAM data output, the address mux (o_address) and the accumulator register (result).
// PARAMETERS
//  ADDR_BITS  5  operand address width; instruction low field is value[ADDR_BITS-1:0]
//  DATA_BITS  8  data/accumulator width; opcode is value[DATA_BITS-1:DATA_BITS-3]
// PORTS
//  clk        in   1  system clock; all state updates on rising edge
//  reset      in   1  synchronous, active-high reset
//  enable     in   1  global enable; when 0 every register holds its value
//  decode_en  in   1  decode phase strobe (from fde)
//  execute_en in   1  execute phase strobe (from fde)
//  value      in   8  RAM data out: instruction byte during decode, operand during execute
//  accu       in   8  current accumulator value (ALU rhs operand)
//  half_clk   out  1  clk/2 phase clock
//  o_address  out  5  latched operand address, to the RAM address mux
//  o_instr    out  8  latched full instruction byte
//  o_store    out  1  RAM write enable
//  result     out  8  registered ALU result, to the accumulator input
//  o_carry    out  1  carry out of the last ADD
//  o_zero     out  1  result == 0 after the last executed instruction
// BEHAVIOUR
//  Reset, clk edge with reset=1: every output register goes to 0 (half_clk, o_address, o_instr, result, o_carry, o_zero). Reset overrides enable.
//  Divider: on each clk edge with enable=1, half_clk <= ~half_clk. Result is a 50% duty square wave at clk/2.
//  Controller: on a clk edge with enable & decode_en:
//   - o_instr <= value
//   - o_address <= value[4:0]
//   - otherwise holds.
//  Opcode field is o_instr[7:5]:
//   - 001 LD
//   - 010 ADD
//   - 011 SUB
//   - 100 STR
//   - all other codes are NOP.
//  o_store is combinational: (o_instr[7:5]==3'b100) & execute_en & enable & ~reset.
//  ALU: on a clk edge with enable & execute_en, using the latched opcode:
//   - LD:  result <= value
//   - ADD: {o_carry,result} <= value + accu (9-bit sum, result wraps mod 256)
//   - SUB: result <= accu - value (mod 256); o_carry <= borrow (value > accu)
//   - STR: result <= accu, so the accumulator is unchanged
//   - NOP/undefined: result and o_carry hold
//   - o_zero <= (new result == 0), updated for every opcode except NOP.
//   - o_carry is only changed by ADD and SUB.
//  Latency: result is valid one clk after the execute edge. o_address is valid one clk after the decode edge.
//  Simultaneous decode_en & execute_en: the ALU executes the previously latched opcode; the controller latches the new byte on the same edge.
//  No execute_en: the ALU never updates, regardless of decode activity.
//  Reset mid-instruction: the latched instruction is cleared to 000 (NOP), so a following execute holds result=0.
// TESTING
//  1. Assert reset 2 clks -> all outputs 0. Then release and toggle clk 4 times -> half_clk toggles every clk edge.
//  2. Decode value=0x23, then execute with value=2, accu=0 -> o_address=3, result=2, o_zero=0.
//  3. Decode 0x44, then execute with value=5, accu=2 -> o_address=4, result=7, o_carry=0.
//  4. Decode 0x85, then execute with accu=7 -> o_address=5; o_store=1 only while execute_en=1; result=7.
//  5. ADD with value=0xFF, accu=0x01 -> result=0x00, o_carry=1, o_zero=1.
//     SUB with value=3, accu=1 -> result=0xFE, o_carry=1.
//  6. enable=0 while execute_en=1 -> all registers hold and o_store=0.
//     Reset between decode and execute -> o_instr=0 and the following execute leaves result=0.

Source files
------------

// File: rtl/byteblast8_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : byteblast8_exec_unit
// Purpose  : ByteBlast 8-bit CPU decode/execute core. Contains the clk/2
//            phase divider, the instruction latch (opcode and operand
//            address) and the 8-bit accumulator ALU with carry/zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module byteblast8_exec_unit #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 decode_en,
  input  logic                 execute_en,
  input  logic [DATA_BITS-1:0] value,
  input  logic [DATA_BITS-1:0] accu,
  output logic                 half_clk,
  output logic [ADDR_BITS-1:0] o_address,
  output logic [DATA_BITS-1:0] o_instr,
  output logic                 o_store,
  output logic [DATA_BITS-1:0] result,
  output logic                 o_carry,
  output logic                 o_zero
);

  // Opcode encodings carried in the top three instruction bits
  localparam logic [2:0] c_op_ld  = 3'b001;
  localparam logic [2:0] c_op_add = 3'b010;
  localparam logic [2:0] c_op_sub = 3'b011;
  localparam logic [2:0] c_op_str = 3'b100;

  logic                 r_half_clk;
  logic [ADDR_BITS-1:0] r_address;
  logic [DATA_BITS-1:0] r_instr;
  logic [DATA_BITS-1:0] r_result;
  logic                 r_carry;
  logic                 r_zero;

  logic [2:0]           w_opcode;
  logic [DATA_BITS:0]   w_sum;
  logic [DATA_BITS:0]   w_diff;
  logic [DATA_BITS-1:0] w_alu_result;
  logic                 w_alu_carry;
  logic                 w_result_upd;
  logic                 w_carry_upd;
  logic                 w_alu_fire;

  assign w_opcode   = r_instr[DATA_BITS-1:DATA_BITS-3];
  assign w_alu_fire = enable & execute_en;

  // Extra top bit of the widened sum/difference is the carry/borrow
  assign w_sum  = {1'b0, value} + {1'b0, accu};
  assign w_diff = {1'b0, accu} - {1'b0, value};

  // Phase divider: toggles on every enabled clock
  always_ff @(posedge clk) begin
    if (reset) begin
      r_half_clk <= 1'b0;
    end else if (enable) begin
      r_half_clk <= ~r_half_clk;
    end
  end

  // Instruction latch: captures the RAM byte during the decode phase
  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr   <= '0;
      r_address <= '0;
    end else if (enable && decode_en) begin
      r_instr   <= value;
      r_address <= value[ADDR_BITS-1:0];
    end
  end

  // ALU datapath: next result/carry and which of them the opcode touches
  always_comb begin
    w_alu_result = r_result;
    w_alu_carry  = r_carry;
    w_result_upd = 1'b0;
    w_carry_upd  = 1'b0;
    case (w_opcode)
      c_op_ld: begin
        w_alu_result = value;
        w_result_upd = 1'b1;
      end
      c_op_add: begin
        w_alu_result = w_sum[DATA_BITS-1:0];
        w_alu_carry  = w_sum[DATA_BITS];
        w_result_upd = 1'b1;
        w_carry_upd  = 1'b1;
      end
      c_op_sub: begin
        w_alu_result = w_diff[DATA_BITS-1:0];
        w_alu_carry  = w_diff[DATA_BITS];
        w_result_upd = 1'b1;
        w_carry_upd  = 1'b1;
      end
      c_op_str: begin
        // Pass the accumulator through so it is left unchanged
        w_alu_result = accu;
        w_result_upd = 1'b1;
      end
      default: begin
        w_result_upd = 1'b0;
      end
    endcase
  end

  // ALU registers: result, carry and zero flag updated on execute
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else if (w_alu_fire) begin
      if (w_result_upd) begin
        r_result <= w_alu_result;
        r_zero   <= (w_alu_result == '0);
      end
      if (w_carry_upd) begin
        r_carry <= w_alu_carry;
      end
    end
  end

  assign half_clk  = r_half_clk;
  assign o_address = r_address;
  assign o_instr   = r_instr;
  assign result    = r_result;
  assign o_carry   = r_carry;
  assign o_zero    = r_zero;
  assign o_store   = (w_opcode == c_op_str) & execute_en & enable & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_byteblast8_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_byteblast8_exec_unit
// Purpose  : Self-checking bench for byteblast8_exec_unit: directed scenarios
//            followed by random traffic against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_byteblast8_exec_unit;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       decode_en;
  logic       execute_en;
  logic [7:0] value;
  logic [7:0] accu;
  logic       half_clk;
  logic [4:0] o_address;
  logic [7:0] o_instr;
  logic       o_store;
  logic [7:0] result;
  logic       o_carry;
  logic       o_zero;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_half, m_addr, m_instr, m_result, m_carry, m_zero;

  byteblast8_exec_unit #(.ADDR_BITS(5), .DATA_BITS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .decode_en  (decode_en),
    .execute_en (execute_en),
    .value      (value),
    .accu       (accu),
    .half_clk   (half_clk),
    .o_address  (o_address),
    .o_instr    (o_instr),
    .o_store    (o_store),
    .result     (result),
    .o_carry    (o_carry),
    .o_zero     (o_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected
  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one clock edge, computed from the instruction-set rules
  task automatic model_edge(input int r, input int en, input int dec,
                            input int ex, input int v, input int a);
    int op;
    int s;
    op = m_instr / 32;
    if (r != 0) begin
      m_half = 0; m_addr = 0; m_instr = 0;
      m_result = 0; m_carry = 0; m_zero = 0;
    end else if (en != 0) begin
      m_half = 1 - m_half;
      if (ex != 0) begin
        if (op == 1) begin
          m_result = v;
        end else if (op == 2) begin
          s = v + a;
          m_result = s % 256;
          m_carry  = (s > 255) ? 1 : 0;
        end else if (op == 3) begin
          m_result = (a - v + 256) % 256;
          m_carry  = (v > a) ? 1 : 0;
        end else if (op == 4) begin
          m_result = a;
        end
        if (op >= 1 && op <= 4) m_zero = (m_result == 0) ? 1 : 0;
      end
      if (dec != 0) begin
        m_instr = v;
        m_addr  = v % 32;
      end
    end
  endtask

  // Drive one cycle, check the store strobe before the edge and all
  // registered outputs shortly after it
  task automatic cycle(input int r, input int en, input int dec,
                       input int ex, input int v, input int a);
    int exp_store;
    reset      = (r != 0);
    enable     = (en != 0);
    decode_en  = (dec != 0);
    execute_en = (ex != 0);
    value      = v[7:0];
    accu       = a[7:0];
    #1;
    exp_store = ((m_instr / 32) == 4 && ex != 0 && en != 0 && r == 0) ? 1 : 0;
    chk("o_store", int'(o_store), exp_store);
    @(posedge clk);
    model_edge(r, en, dec, ex, v, a);
    #1;
    chk("half_clk",  int'(half_clk),  m_half);
    chk("o_address", int'(o_address), m_addr);
    chk("o_instr",   int'(o_instr),   m_instr);
    chk("result",    int'(result),    m_result);
    chk("o_carry",   int'(o_carry),   m_carry);
    chk("o_zero",    int'(o_zero),    m_zero);
  endtask

  // Stimulus: directed scenarios then randomized traffic
  initial begin
    m_half = 0; m_addr = 0; m_instr = 0;
    m_result = 0; m_carry = 0; m_zero = 0;
    reset = 1'b1; enable = 1'b0; decode_en = 1'b0; execute_en = 1'b0;
    value = '0; accu = '0;
    @(posedge clk);
    #1;

    // Reset for two clocks, then free-running divider
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("rst_result", int'(result), 0);
    chk("rst_half",   int'(half_clk), 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 0, 0);
      chk("div_toggle", int'(half_clk), (i % 2 == 0) ? 1 : 0);
    end

    // LD
    cycle(0, 1, 1, 0, 8'h23, 0);
    cycle(0, 1, 0, 1, 2, 0);
    chk("ld_addr", int'(o_address), 3);
    chk("ld_res",  int'(result), 2);
    chk("ld_zero", int'(o_zero), 0);

    // ADD
    cycle(0, 1, 1, 0, 8'h44, 2);
    cycle(0, 1, 0, 1, 5, 2);
    chk("add_addr",  int'(o_address), 4);
    chk("add_res",   int'(result), 7);
    chk("add_carry", int'(o_carry), 0);

    // STR: strobe only while execute_en is high
    cycle(0, 1, 1, 0, 8'h85, 7);
    chk("str_addr", int'(o_address), 5);
    cycle(0, 1, 0, 1, 8'h11, 7);
    chk("str_res", int'(result), 7);
    execute_en = 1'b1;
    #1;
    chk("str_strobe_hi", int'(o_store), 1);
    execute_en = 1'b0;
    #1;
    chk("str_strobe_lo", int'(o_store), 0);

    // ADD wrap with carry and zero, then SUB with borrow
    cycle(0, 1, 1, 0, 8'h40, 0);
    cycle(0, 1, 0, 1, 8'hFF, 8'h01);
    chk("addw_res",   int'(result), 0);
    chk("addw_carry", int'(o_carry), 1);
    chk("addw_zero",  int'(o_zero), 1);
    cycle(0, 1, 1, 0, 8'h60, 0);
    cycle(0, 1, 0, 1, 3, 1);
    chk("sub_res",   int'(result), 8'hFE);
    chk("sub_carry", int'(o_carry), 1);

    // enable low holds everything, including a pending execute
    cycle(0, 1, 1, 0, 8'h21, 0);
    cycle(0, 0, 1, 1, 8'h99, 0);
    chk("hold_res",   int'(result), 8'hFE);
    chk("hold_instr", int'(o_instr), 8'h21);

    // Reset between decode and execute leaves a NOP behind
    cycle(0, 1, 1, 0, 8'h23, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 9, 4);
    chk("rstmid_instr", int'(o_instr), 0);
    chk("rstmid_res",   int'(result), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(31) == 0) ? 1 : 0,
            ($urandom_range(7) != 0) ? 1 : 0,
            int'($urandom_range(1)),
            int'($urandom_range(1)),
            int'($urandom_range(255)),
            int'($urandom_range(255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
